// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the 6502 fetch stage and its decoder.
// FETCH_RESET_VECTOR_EN adds the reset-vector boot states to fetch_state_t.
package fetch_unit_pkg;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h8000;
  localparam logic [15:0] VEC_ADDR_DEFAULT = 16'hFFFC;

  typedef logic [1:0] instr_len_t;
  localparam instr_len_t LEN1 = 2'd1;
  localparam instr_len_t LEN2 = 2'd2;
  localparam instr_len_t LEN3 = 2'd3;

  typedef enum logic [2:0] {
`ifdef FETCH_RESET_VECTOR_EN
    ST_VEC_LO   = 3'd0,
    ST_VEC_HI   = 3'd1,
`endif
    ST_FETCH_OP = 3'd2,
    ST_FETCH_B1 = 3'd3,
    ST_FETCH_B2 = 3'd4,
    ST_HOLD     = 3'd5
  } fetch_state_t;

  // Opcode is split as aaa_bbb_cc: group (C), addressing mode (B), operation (A).
  localparam int FIELD_C_LSB = 0;
  localparam int FIELD_C_MSB = 1;
  localparam int FIELD_B_LSB = 2;
  localparam int FIELD_B_MSB = 4;
  localparam int FIELD_A_LSB = 5;
  localparam int FIELD_A_MSB = 7;
  localparam logic [1:0] GROUP_C0 = 2'b00;
  localparam logic [1:0] GROUP_C1 = 2'b01;
  localparam logic [1:0] GROUP_C2 = 2'b10;

endpackage

// File: rtl/fetch_unit_instr_len_lut.sv
// Combinational 6502 instruction length lookup (documented opcodes only;
// every undocumented opcode is reported as a single byte).
module instr_len_lut
  import fetch_unit_pkg::*;
(
  input  logic [7:0] i_opcode,
  output instr_len_t o_len
);

  always_comb begin
    o_len = LEN1;
    casez (i_opcode)
      // Group C0: control flow, BIT, index register loads/stores/compares
      8'h20:                                    o_len = LEN3;
      8'hA0, 8'hC0, 8'hE0:                      o_len = LEN2;
      8'h24, 8'h84, 8'hA4, 8'hC4, 8'hE4:        o_len = LEN2;
      8'h2C, 8'h4C, 8'h6C, 8'h8C,
      8'hAC, 8'hCC, 8'hEC:                      o_len = LEN3;
      8'b???_100_00:                            o_len = LEN2;
      8'h94, 8'hB4:                             o_len = LEN2;
      8'hBC:                                    o_len = LEN3;
      // Group C1: ALU ops; 0x89 (STA immediate) does not exist
      8'b???_000_01, 8'b???_001_01,
      8'b0??_010_01, 8'b11?_010_01, 8'b101_010_01,
      8'b???_100_01, 8'b???_101_01:             o_len = LEN2;
      8'b???_011_01, 8'b???_110_01,
      8'b???_111_01:                            o_len = LEN3;
      // Group C2: shifts, INC/DEC, X register; 0x9E does not exist
      8'hA2:                                    o_len = LEN2;
      8'b???_001_10, 8'b???_101_10:             o_len = LEN2;
      8'b???_011_10,
      8'b0??_111_10, 8'b11?_111_10, 8'b101_111_10: o_len = LEN3;
      default:                                  o_len = LEN1;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// 6502 instruction fetch: reads 1-3 bytes, presents a bundle over valid/ready.
// Define FETCH_RESET_VECTOR_EN to boot from the reset vector at VEC_ADDR.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [15:0] VEC_ADDR = VEC_ADDR_DEFAULT
)
(
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [15:0] mem_addr_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_rvalid_i,
  input  logic        pc_load_i,
  input  logic [15:0] pc_load_addr_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [7:0]  opcode_o,
  output logic [15:0] data_o,
  output logic [15:0] pc_o,
  output logic [15:0] next_pc_o
);

`ifdef FETCH_RESET_VECTOR_EN
  localparam bit           VECTOR_BOOT = 1'b1;
  localparam fetch_state_t BOOT_STATE  = ST_VEC_LO;
`else
  localparam bit           VECTOR_BOOT = 1'b0;
  localparam fetch_state_t BOOT_STATE  = ST_FETCH_OP;
`endif
  localparam logic [15:0] BOOT_FETCH_PC = VECTOR_BOOT ? VEC_ADDR : RESET_PC;
  localparam logic [15:0] RESET_OUT_PC  = VECTOR_BOOT ? 16'h0000 : RESET_PC;

  fetch_state_t r_state, w_nextState;
  logic         r_memReq, r_outstanding, r_discard, r_valid;
  logic [15:0]  r_memAddr, r_fetchPc, r_instrPc;
  logic [7:0]   r_opByte, r_b1, r_opcodeOut;
  logic [15:0]  r_dataOut, r_pcOut, r_nextPcOut;
  instr_len_t   r_len, w_lutLen;
  logic [15:0]  w_nextFetchPc;
  logic         w_inVec, w_redirect, w_capture, w_accept;
  logic         w_outstandingNext, w_issue, w_bundleDone;

  instr_len_lut u_lenLut (
    .i_opcode (mem_rdata_i),
    .o_len    (w_lutLen)
  );

`ifdef FETCH_RESET_VECTOR_EN
  assign w_inVec = (r_state == ST_VEC_LO) || (r_state == ST_VEC_HI);
`else
  assign w_inVec = 1'b0;
`endif

  // A byte is only used if it answers a live read and no redirect kills it.
  assign w_redirect        = pc_load_i && !w_inVec;
  assign w_capture         = mem_rvalid_i && r_outstanding && !r_discard && !w_redirect;
  assign w_accept          = r_valid && ready_i;
  assign w_outstandingNext = r_outstanding && !mem_rvalid_i;
  assign w_issue           = (w_nextState != ST_HOLD) && !w_outstandingNext;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= BOOT_STATE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    w_bundleDone = 1'b0;
    if (w_redirect) begin
      w_nextState = ST_FETCH_OP;
    end else begin
      case (r_state)
`ifdef FETCH_RESET_VECTOR_EN
        ST_VEC_LO:   if (w_capture) w_nextState = ST_VEC_HI;
        ST_VEC_HI:   if (w_capture) w_nextState = ST_FETCH_OP;
`endif
        ST_FETCH_OP: if (w_capture) begin
          if (w_lutLen == LEN1) begin
            w_nextState  = ST_HOLD;
            w_bundleDone = 1'b1;
          end else begin
            w_nextState = ST_FETCH_B1;
          end
        end
        ST_FETCH_B1: if (w_capture) begin
          if (r_len == LEN3) begin
            w_nextState = ST_FETCH_B2;
          end else begin
            w_nextState  = ST_HOLD;
            w_bundleDone = 1'b1;
          end
        end
        ST_FETCH_B2: if (w_capture) begin
          w_nextState  = ST_HOLD;
          w_bundleDone = 1'b1;
        end
        ST_HOLD:     if (w_accept) w_nextState = ST_FETCH_OP;
        default:     w_nextState = BOOT_STATE;
      endcase
    end
  end

  always_comb begin
    w_nextFetchPc = r_fetchPc;
    if (w_redirect) begin
      w_nextFetchPc = pc_load_addr_i;
    end else if (w_capture) begin
      w_nextFetchPc = r_fetchPc + 16'd1;
`ifdef FETCH_RESET_VECTOR_EN
      if (r_state == ST_VEC_HI) w_nextFetchPc = {mem_rdata_i, r_b1};
`endif
    end
  end

  // Requests are registered so the pulse starts the cycle after the decision;
  // a redirected read stays outstanding (discarded) until its data returns.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_memReq      <= 1'b0;
      r_memAddr     <= BOOT_FETCH_PC;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
      r_fetchPc     <= BOOT_FETCH_PC;
      r_instrPc     <= 16'h0000;
      r_opByte      <= 8'h00;
      r_b1          <= 8'h00;
      r_len         <= LEN1;
    end else begin
      r_memReq      <= w_issue;
      if (w_issue) r_memAddr <= w_nextFetchPc;
      r_outstanding <= w_issue || w_outstandingNext;
      if (mem_rvalid_i)                    r_discard <= 1'b0;
      else if (w_redirect && r_outstanding) r_discard <= 1'b1;
      r_fetchPc     <= w_nextFetchPc;
      if (w_capture) begin
        case (r_state)
`ifdef FETCH_RESET_VECTOR_EN
          ST_VEC_LO:   r_b1 <= mem_rdata_i;
`endif
          ST_FETCH_OP: begin
            r_opByte  <= mem_rdata_i;
            r_len     <= w_lutLen;
            r_instrPc <= r_fetchPc;
          end
          ST_FETCH_B1: r_b1 <= mem_rdata_i;
          default:     ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid     <= 1'b0;
      r_opcodeOut <= 8'h00;
      r_dataOut   <= 16'h0000;
      r_pcOut     <= RESET_OUT_PC;
      r_nextPcOut <= RESET_OUT_PC;
    end else if (w_redirect) begin
      r_valid <= 1'b0;
    end else if (w_bundleDone) begin
      r_valid     <= 1'b1;
      r_nextPcOut <= w_nextFetchPc;
      case (r_state)
        ST_FETCH_B1: begin
          r_opcodeOut <= r_opByte;
          r_dataOut   <= {mem_rdata_i, 8'h00};
          r_pcOut     <= r_instrPc;
        end
        ST_FETCH_B2: begin
          r_opcodeOut <= r_opByte;
          r_dataOut   <= {r_b1, mem_rdata_i};
          r_pcOut     <= r_instrPc;
        end
        default: begin
          r_opcodeOut <= mem_rdata_i;
          r_dataOut   <= 16'h0000;
          r_pcOut     <= r_fetchPc;
        end
      endcase
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign mem_req_o  = r_memReq;
  assign mem_addr_o = r_memAddr;
  assign valid_o    = r_valid;
  assign opcode_o   = r_opcodeOut;
  assign data_o     = r_dataOut;
  assign pc_o       = r_pcOut;
  assign next_pc_o  = r_nextPcOut;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of single instructions plus hand-written
// sequences for backpressure, redirect during a read, and redirect on accept.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  memRdata = 8'h00;
  logic        memRvalid = 1'b0;
  logic        pc_load_i;
  logic [15:0] pc_load_addr_i;
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  opcode_o;
  logic [15:0] data_o;
  logic [15:0] pc_o;
  logic [15:0] next_pc_o;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0]  mem [65536];
  logic [15:0] reqLog [$];
  int          memLatency = 1;
  int          pendCnt = 0;
  logic [15:0] pendAddr = 16'h0000;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  b0, b1, b2;
    int          len;
    logic [7:0]  expOp;
    logic [15:0] expData;
    logic [15:0] expNext;
  } vec_t;

  vec_t vecs [15];

  fetch_unit dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_rdata_i    (memRdata),
    .mem_rvalid_i   (memRvalid),
    .pc_load_i      (pc_load_i),
    .pc_load_addr_i (pc_load_addr_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .opcode_o       (opcode_o),
    .data_o         (data_o),
    .pc_o           (pc_o),
    .next_pc_o      (next_pc_o)
  );

  initial forever #5 clk_i = ~clk_i;

  // Byte-wide memory: answers each request after memLatency cycles.
  always @(posedge clk_i) begin
    memRvalid <= 1'b0;
    if (mem_req_o) begin
      reqLog.push_back(mem_addr_o);
      if (memLatency <= 1) begin
        memRvalid <= 1'b1;
        memRdata  <= mem[mem_addr_o];
        pendCnt   <= 0;
      end else begin
        pendAddr <= mem_addr_o;
        pendCnt  <= memLatency - 1;
      end
    end else if (pendCnt > 0) begin
      pendCnt <= pendCnt - 1;
      if (pendCnt == 1) begin
        memRvalid <= 1'b1;
        memRdata  <= mem[pendAddr];
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic waitValid(input int budget, input string tag);
    int n = 0;
    while (!valid_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    if (!valid_o) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s_timeout: valid_o=0 after %0d cycles, required 1", tag, budget);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    mem[v.pc]          = v.b0;
    mem[v.pc + 16'd1]  = v.b1;
    mem[v.pc + 16'd2]  = v.b2;
    reqLog.delete();
    pc_load_addr_i = v.pc;
    pc_load_i      = 1'b1;
    @(negedge clk_i);
    pc_load_i = 1'b0;
    waitValid(40, "vec");
  endtask

  logic [15:0] bootPc;
  logic [15:0] resetPc;
  logic [15:0] expAddr;
  logic [15:0] gotAddr;
  int          reqsBefore;
  int          n;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    vecs[0]  = '{16'h8000, 8'hAD, 8'h34, 8'h12, 3, 8'hAD, 16'h3412, 16'h8003};
    vecs[1]  = '{16'h8000, 8'hA9, 8'h05, 8'h77, 2, 8'hA9, 16'h0500, 16'h8002};
    vecs[2]  = '{16'hFFFF, 8'h4C, 8'h00, 8'h80, 3, 8'h4C, 16'h0080, 16'h0002};
    vecs[3]  = '{16'h1234, 8'h02, 8'h55, 8'h66, 1, 8'h02, 16'h0000, 16'h1235};
    vecs[4]  = '{16'h2000, 8'h20, 8'h00, 8'h90, 3, 8'h20, 16'h0090, 16'h2003};
    vecs[5]  = '{16'h3000, 8'h10, 8'hFE, 8'h99, 2, 8'h10, 16'hFE00, 16'h3002};
    vecs[6]  = '{16'h4000, 8'h6C, 8'h34, 8'h12, 3, 8'h6C, 16'h3412, 16'h4003};
    vecs[7]  = '{16'h5000, 8'h89, 8'h11, 8'h22, 1, 8'h89, 16'h0000, 16'h5001};
    vecs[8]  = '{16'h5100, 8'h9E, 8'h33, 8'h44, 1, 8'h9E, 16'h0000, 16'h5101};
    vecs[9]  = '{16'h5200, 8'hBE, 8'h10, 8'h20, 3, 8'hBE, 16'h1020, 16'h5203};
    vecs[10] = '{16'h5300, 8'h60, 8'hAA, 8'hBB, 1, 8'h60, 16'h0000, 16'h5301};
    vecs[11] = '{16'h5400, 8'hB6, 8'h44, 8'hCC, 2, 8'hB6, 16'h4400, 16'h5402};
    vecs[12] = '{16'hFFFE, 8'h8D, 8'h11, 8'h22, 3, 8'h8D, 16'h1122, 16'h0001};
    vecs[13] = '{16'h6000, 8'hA1, 8'h20, 8'hDD, 2, 8'hA1, 16'h2000, 16'h6002};
    vecs[14] = '{16'h6100, 8'h0A, 8'h01, 8'h02, 1, 8'h0A, 16'h0000, 16'h6101};

`ifdef FETCH_RESET_VECTOR_EN
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'hC0;
    resetPc = 16'h0000;
    bootPc  = 16'hC000;
    expAddr = 16'hFFFC;
`else
    resetPc = 16'h8000;
    bootPc  = 16'h8000;
    expAddr = 16'h8000;
`endif

    rst_i = 1'b1; pc_load_i = 1'b0; pc_load_addr_i = 16'h0000; ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst valid_o", {15'b0, valid_o}, 16'h0000);
    checkOutput("rst mem_req_o", {15'b0, mem_req_o}, 16'h0000);
    checkOutput("rst opcode_o", {8'h00, opcode_o}, 16'h0000);
    checkOutput("rst data_o", data_o, 16'h0000);
    checkOutput("rst pc_o", pc_o, resetPc);
    checkOutput("rst next_pc_o", next_pc_o, resetPc);

    reqLog.delete();
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("boot first req", {15'b0, mem_req_o}, 16'h0001);
    checkOutput("boot first addr", mem_addr_o, expAddr);
    waitValid(40, "boot");
`ifdef FETCH_RESET_VECTOR_EN
    checkOutput("vec req count", 16'(reqLog.size()), 16'd3);
    gotAddr = (reqLog.size() > 1) ? reqLog[1] : 16'h0000;
    checkOutput("vec hi addr", gotAddr, 16'hFFFD);
    gotAddr = (reqLog.size() > 2) ? reqLog[2] : 16'h0000;
    checkOutput("vec opcode addr", gotAddr, 16'hC000);
`endif
    checkOutput("boot opcode_o", {8'h00, opcode_o}, 16'h00EA);
    checkOutput("boot data_o", data_o, 16'h0000);
    checkOutput("boot pc_o", pc_o, bootPc);
    checkOutput("boot next_pc_o", next_pc_o, bootPc + 16'd1);

    // Backpressure: bundle must hold and no fetch may start.
    reqsBefore = reqLog.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checkOutput("bp valid_o", {15'b0, valid_o}, 16'h0001);
      checkOutput("bp pc_o", pc_o, bootPc);
    end
    checkOutput("bp no requests", 16'(reqLog.size()), 16'(reqsBefore));
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    checkOutput("bp next req", {15'b0, mem_req_o}, 16'h0001);
    checkOutput("bp next addr", mem_addr_o, bootPc + 16'd1);
    waitValid(40, "bp");
    checkOutput("bp second pc_o", pc_o, bootPc + 16'd1);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d opcode_o", i), {8'h00, opcode_o}, {8'h00, vecs[i].expOp});
      checkOutput($sformatf("vec%0d data_o", i), data_o, vecs[i].expData);
      checkOutput($sformatf("vec%0d pc_o", i), pc_o, vecs[i].pc);
      checkOutput($sformatf("vec%0d next_pc_o", i), next_pc_o, vecs[i].expNext);
      checkOutput($sformatf("vec%0d req count", i), 16'(reqLog.size()), 16'(vecs[i].len));
      for (int k = 0; k < vecs[i].len; k++) begin
        expAddr = vecs[i].pc + 16'(k);
        gotAddr = (k < reqLog.size()) ? reqLog[k] : 16'hxxxx;
        checkOutput($sformatf("vec%0d req%0d addr", i, k), gotAddr, expAddr);
      end
    end

    // Redirect while the first operand read is outstanding on slow memory.
    memLatency = 3;
    mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
    mem[16'hC000] = 8'hEA;
    reqLog.delete();
    pc_load_addr_i = 16'h8000;
    pc_load_i = 1'b1;
    @(negedge clk_i);
    pc_load_i = 1'b0;
    n = 0;
    while (!(mem_req_o && mem_addr_o == 16'h8001) && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("redir b1 req seen", {15'b0, (mem_req_o && mem_addr_o == 16'h8001)}, 16'h0001);
    @(negedge clk_i);
    pc_load_addr_i = 16'hC000;
    pc_load_i = 1'b1;
    @(negedge clk_i);
    pc_load_i = 1'b0;
    checkOutput("redir valid low", {15'b0, valid_o}, 16'h0000);
    waitValid(60, "redir");
    checkOutput("redir pc_o", pc_o, 16'hC000);
    checkOutput("redir opcode_o", {8'h00, opcode_o}, 16'h00EA);
    checkOutput("redir data_o", data_o, 16'h0000);
    checkOutput("redir next_pc_o", next_pc_o, 16'hC001);
    checkOutput("redir req count", 16'(reqLog.size()), 16'd3);
    gotAddr = (reqLog.size() > 2) ? reqLog[2] : 16'h0000;
    checkOutput("redir new addr", gotAddr, 16'hC000);
    memLatency = 1;

    // Redirect in the same cycle the decoder accepts the bundle.
    mem[16'hD000] = 8'hEA;
    ready_i = 1'b1;
    pc_load_addr_i = 16'hD000;
    pc_load_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    pc_load_i = 1'b0;
    checkOutput("acc+redir valid_o", {15'b0, valid_o}, 16'h0000);
    checkOutput("acc+redir req", {15'b0, mem_req_o}, 16'h0001);
    checkOutput("acc+redir addr", mem_addr_o, 16'hD000);
    waitValid(40, "accredir");
    checkOutput("acc+redir pc_o", pc_o, 16'hD000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
